// File: rtl/actuation_voter.sv
// -----------------------------------------------------------------------------
// actuation_voter
//
// K-of-NDIV coincidence voter with per-channel persistence filtering and a
// sticky trip latch. Each of NCH trip channels is voted across NDIV
// instrumentation divisions. A channel trips after PERSIST consecutive valid
// samples show coincidence. Once tripped, it stays tripped until an operator
// clear is accepted on a clean (non-coincident) sample.
//
// Configuration macro:
//   VOTE_BYPASS_EN - when defined, the bypass port removes divisions from the
//                    vote and drives degraded. When undefined, bypass is
//                    ignored, every division votes, and degraded is 0.
//
// Parameters:
//   NDIV    - number of instrumentation divisions
//   NCH     - number of trip channels
//   TRIP_W  - width of each trip field
//   K       - coincidence threshold (1..NDIV)
//   PERSIST - consecutive coincident samples needed to trip (>= 1)
//
// Ports:
//   clk        - clock; all state changes on the rising edge
//   rst        - asynchronous active-high reset
//   in_valid   - inp carries a new sample this cycle
//   inp        - packed trip fields; division d, channel c sits at bit offset
//                TRIP_W*(NCH*(NDIV-1-d)+(NCH-1-c))
//   bypass     - per-division maintenance bypass
//   clear_req  - per-channel request to clear a latched vote
//   clear_ack  - one-cycle pulse when a clear request is accepted
//   votes      - latched trip vote per channel
//   pending    - channel is persistence-counting toward a trip
//   degraded   - fewer than K divisions remain unbypassed
// -----------------------------------------------------------------------------
module actuation_voter #(
  parameter int NDIV    = 4,
  parameter int NCH     = 3,
  parameter int TRIP_W  = 8,
  parameter int K       = 2,
  parameter int PERSIST = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  input  logic [NDIV*NCH*TRIP_W-1:0]  inp,
  input  logic [NDIV-1:0]             bypass,
  input  logic [NCH-1:0]              clear_req,
  output logic [NCH-1:0]              clear_ack,
  output logic [NCH-1:0]              votes,
  output logic [NCH-1:0]              pending,
  output logic                        degraded
);

  localparam int CW = $clog2(PERSIST + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PEND,
    S_TRIP
  } state_t;

  // Divisions that take part in the vote.
  logic [NDIV-1:0] w_div_en;
  logic            w_degraded;

`ifdef VOTE_BYPASS_EN
  assign w_div_en = ~bypass;

  always_comb begin
    int n_byp;
    n_byp = 0;
    for (int d = 0; d < NDIV; d++) begin
      if (bypass[d]) n_byp = n_byp + 1;
    end
    w_degraded = (NDIV - n_byp) < K;
  end
`else
  // Bypass is wired but has no effect in this build.
  logic w_unused_bypass;
  assign w_unused_bypass = ^bypass;
  assign w_div_en        = '1;
  assign w_degraded      = 1'b0;
`endif

  // Coincidence per channel. A field trips only on the exact value 1. Any
  // other pattern, including values with bit 0 set, counts as not tripped.
  logic [NCH-1:0] w_coin;

  always_comb begin
    int n_trip;
    // NOTE: every variable written here gets a value before any branch
    // reads it, so no path leaves it unassigned and no latch is inferred.
    w_coin = '0;
    n_trip = 0;
    for (int c = 0; c < NCH; c++) begin
      n_trip = 0;
      for (int d = 0; d < NDIV; d++) begin
        if (w_div_en[d] &&
            inp[TRIP_W*(NCH*(NDIV-1-d)+(NCH-1-c)) +: TRIP_W] == TRIP_W'(1)) begin
          n_trip = n_trip + 1;
        end
      end
      w_coin[c] = (n_trip >= K);
    end
  end

  logic r_degraded;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_degraded <= 1'b0;
    else     r_degraded <= w_degraded;
  end

  assign degraded = r_degraded;

  // One independent persistence FSM per channel.
  for (genvar c = 0; c < NCH; c++) begin : g_ch
    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_ack_nxt;
    logic            r_vote;
    logic            r_pend;
    logic            r_ack;

    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = 1'b0;

      unique case (r_state)
        S_IDLE: begin
          // A clear in IDLE is acknowledged at once. It takes priority
          // over a coincident sample arriving in the same cycle.
          if (clear_req[c]) begin
            w_ack_nxt = 1'b1;
          end else if (in_valid && w_coin[c]) begin
            if (PERSIST == 1) begin
              w_state_nxt = S_TRIP;
            end else begin
              w_state_nxt = S_PEND;
              w_cnt_nxt   = CW'(1);
            end
          end
        end

        S_PEND: begin
          if (clear_req[c]) begin
            // Operator abort: discard partial persistence.
            w_ack_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (in_valid) begin
            if (w_coin[c]) begin
              w_cnt_nxt = r_cnt + CW'(1);
              if (r_cnt + CW'(1) == CW'(PERSIST)) w_state_nxt = S_TRIP;
            end else begin
              w_state_nxt = S_IDLE;
              w_cnt_nxt   = '0;
            end
          end
          // Without in_valid, state and count hold: samples need not be
          // back-to-back in clock cycles.
        end

        S_TRIP: begin
          // Sticky. Release only on a clean sample, so a trip cannot be
          // cleared while the plant condition persists.
          if (clear_req[c] && in_valid && !w_coin[c]) begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end

    // NOTE: state registers use non-blocking assignments so that every
    // flop samples the pre-edge values, whatever the order of the blocks.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_vote  <= 1'b0;
        r_pend  <= 1'b0;
        r_ack   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        // Outputs are registered decodes of the next state, so they mirror
        // the state register exactly and change one edge after the sample.
        r_vote  <= (w_state_nxt == S_TRIP);
        r_pend  <= (w_state_nxt == S_PEND);
        r_ack   <= w_ack_nxt;
      end
    end

    assign votes[c]     = r_vote;
    assign pending[c]   = r_pend;
    assign clear_ack[c] = r_ack;
  end

endmodule

// File: tb/tb_actuation_voter.sv
// -----------------------------------------------------------------------------
// tb_actuation_voter
//
// Self-checking bench for actuation_voter with default parameters
// (NDIV=4, NCH=3, TRIP_W=8, K=2, PERSIST=3). Each step drives one cycle of
// stimulus and pushes the outputs expected after that edge onto a queue.
// The outputs are then sampled 1 ns after the edge and compared with the
// popped entry. Non-tripped fields carry random values other than 1.
// -----------------------------------------------------------------------------
module tb_actuation_voter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [95:0] inp;
  logic [3:0]  bypass;
  logic [2:0]  clear_req;
  logic [2:0]  clear_ack;
  logic [2:0]  votes;
  logic [2:0]  pending;
  logic        degraded;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0] votes;
    logic [2:0] pending;
    logic [2:0] ack;
    logic       deg;
  } obs_t;

  typedef struct packed {
    logic       v;
    logic [3:0] m0;   // divisions tripping channel 0 (bit d = division d)
    logic [3:0] m1;
    logic [3:0] m2;
    logic [2:0] clr;
    logic [3:0] byp;
    obs_t       exp;
  } step_t;

  obs_t exp_q[$];

  actuation_voter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .inp       (inp),
    .bypass    (bypass),
    .clear_req (clear_req),
    .clear_ack (clear_ack),
    .votes     (votes),
    .pending   (pending),
    .degraded  (degraded)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic step_t st(input logic v, input logic [3:0] m0,
                               input logic [3:0] m1, input logic [3:0] m2,
                               input logic [2:0] clr, input logic [3:0] byp,
                               input logic [2:0] ev, input logic [2:0] ep,
                               input logic [2:0] ea, input logic ed);
    step_t s;
    s.v = v; s.m0 = m0; s.m1 = m1; s.m2 = m2; s.clr = clr; s.byp = byp;
    s.exp.votes = ev; s.exp.pending = ep; s.exp.ack = ea; s.exp.deg = ed;
    return s;
  endfunction

  // Drive one cycle of stimulus and record the outputs expected after it.
  task automatic apply(input step_t s);
    logic [95:0] d;
    @(negedge clk);
    d = '0;
    for (int dv = 0; dv < 4; dv++) begin
      for (int c = 0; c < 3; c++) begin
        logic [3:0] m;
        int         r;
        m = (c == 0) ? s.m0 : (c == 1) ? s.m1 : s.m2;
        r = $urandom_range(0, 254);
        if (r >= 1) r = r + 1;
        d[8*(3*(3-dv)+(2-c)) +: 8] = m[dv] ? 8'h01 : 8'(r);
      end
    end
    in_valid  = s.v;
    inp       = d;
    clear_req = s.clr;
    bypass    = s.byp;
    exp_q.push_back(s.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    step_t q[$];
    obs_t  obs, want;
    rst = 1'b1; in_valid = 1'b0; inp = '0; bypass = '0; clear_req = '0;
    #12;
    obs = {votes, pending, clear_ack, degraded};
    n_checks++;
    if (obs !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_state: got %b want %b", obs, 10'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++)
      q.push_back(st(1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      obs = {votes, pending, clear_ack, degraded}; want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL reset_idle step %0d: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_basic_trip();
    step_t q[$];
    obs_t  obs, want;
    q.push_back(st(1'b1, 4'h0, 4'b0101, 4'h0, 3'b000, 4'h0, 3'b000, 3'b010, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0, 4'b0101, 4'h0, 3'b000, 4'h0, 3'b000, 3'b010, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0, 4'b0101, 4'h0, 3'b000, 4'h0, 3'b010, 3'b000, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0, 4'h0,    4'h0, 3'b010, 4'h0, 3'b000, 3'b000, 3'b010, 1'b0));
    q.push_back(st(1'b0, 4'h0, 4'h0,    4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      obs = {votes, pending, clear_ack, degraded}; want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL basic_trip step %0d: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_single_div();
    step_t q[$];
    obs_t  obs, want;
    for (int i = 0; i < 10; i++)
      q.push_back(st(1'b1, 4'b1000, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      obs = {votes, pending, clear_ack, degraded}; want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL single_div step %0d: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_restart();
    step_t q[$];
    obs_t  obs, want;
    q.push_back(st(1'b1, 4'b0110, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b001, 3'b000, 1'b0));
    q.push_back(st(1'b0, 4'b0110, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b001, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'b0110, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b001, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0,    4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'b0110, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b001, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'b0110, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b001, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'b0110, 4'h0, 4'h0, 3'b000, 4'h0, 3'b001, 3'b000, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0,    4'h0, 4'h0, 3'b001, 4'h0, 3'b000, 3'b000, 3'b001, 1'b0));
    q.push_back(st(1'b0, 4'h0,    4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      obs = {votes, pending, clear_ack, degraded}; want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL restart step %0d: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_clear();
    step_t q[$];
    obs_t  obs, want;
    // Trip channel 2, then hold clear_req while coincidence persists.
    for (int i = 0; i < 2; i++)
      q.push_back(st(1'b1, 4'h0, 4'h0, 4'hF, 3'b000, 4'h0, 3'b000, 3'b100, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0, 4'h0, 4'hF, 3'b000, 4'h0, 3'b100, 3'b000, 3'b000, 1'b0));
    for (int i = 0; i < 4; i++)
      q.push_back(st(1'b1, 4'h0, 4'h0, 4'hF, 3'b100, 4'h0, 3'b100, 3'b000, 3'b000, 1'b0));
    // Clean data but no in_valid: still refused.
    q.push_back(st(1'b0, 4'h0, 4'h0, 4'h0, 3'b100, 4'h0, 3'b100, 3'b000, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0, 4'h0, 4'h0, 3'b100, 4'h0, 3'b000, 3'b000, 3'b100, 1'b0));
    q.push_back(st(1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    // Abort in PEND on channel 1, then confirm persistence restarts from 1.
    q.push_back(st(1'b1, 4'h0, 4'b0011, 4'h0, 3'b000, 4'h0, 3'b000, 3'b010, 3'b000, 1'b0));
    q.push_back(st(1'b0, 4'h0, 4'h0,    4'h0, 3'b010, 4'h0, 3'b000, 3'b000, 3'b010, 1'b0));
    q.push_back(st(1'b0, 4'h0, 4'h0,    4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    for (int i = 0; i < 2; i++)
      q.push_back(st(1'b1, 4'h0, 4'b0011, 4'h0, 3'b000, 4'h0, 3'b000, 3'b010, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0, 4'b0011, 4'h0, 3'b000, 4'h0, 3'b010, 3'b000, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0, 4'h0,    4'h0, 3'b010, 4'h0, 3'b000, 3'b000, 3'b010, 1'b0));
    q.push_back(st(1'b0, 4'h0, 4'h0,    4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      obs = {votes, pending, clear_ack, degraded}; want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL clear step %0d: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_bypass();
    step_t q[$];
    obs_t  obs, want;
`ifdef VOTE_BYPASS_EN
    // Division 0 bypassed: only division 3 counts, so no coincidence.
    for (int i = 0; i < 3; i++)
      q.push_back(st(1'b1, 4'b1001, 4'h0, 4'h0, 3'b000, 4'b0111, 3'b000, 3'b000, 3'b000, 1'b1));
    q.push_back(st(1'b1, 4'h0, 4'h0, 4'h0, 3'b001, 4'b0111, 3'b000, 3'b000, 3'b001, 1'b1));
`else
    for (int i = 0; i < 2; i++)
      q.push_back(st(1'b1, 4'b1001, 4'h0, 4'h0, 3'b000, 4'b0111, 3'b000, 3'b001, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'b1001, 4'h0, 4'h0, 3'b000, 4'b0111, 3'b001, 3'b000, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0, 4'h0, 4'h0, 3'b001, 4'b0111, 3'b000, 3'b000, 3'b001, 1'b0));
`endif
    q.push_back(st(1'b0, 4'h0, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      obs = {votes, pending, clear_ack, degraded}; want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL bypass step %0d: got %b want %b", i, obs, want);
      end
    end
  endtask

  task automatic test_async_reset();
    step_t q[$];
    step_t r[$];
    obs_t  obs, want;
    // Channel 2 into TRIP, channel 0 into PEND.
    for (int i = 0; i < 2; i++)
      q.push_back(st(1'b1, 4'h0, 4'h0, 4'hF, 3'b000, 4'h0, 3'b000, 3'b100, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'h0,    4'h0, 4'hF, 3'b000, 4'h0, 3'b100, 3'b000, 3'b000, 1'b0));
    q.push_back(st(1'b1, 4'b0011, 4'h0, 4'hF, 3'b000, 4'h0, 3'b100, 3'b001, 3'b000, 1'b0));
    foreach (q[i]) begin
      apply(q[i]);
      obs = {votes, pending, clear_ack, degraded}; want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL async_reset_pre step %0d: got %b want %b", i, obs, want);
      end
    end
    // Pulse reset between clock edges; outputs must clear without a clock.
    #2;
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    obs = {votes, pending, clear_ack, degraded};
    n_checks++;
    if (obs !== 10'b0) begin
      n_errors++;
      $display("FAIL async_reset_clear: got %b want %b", obs, 10'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    // Persistence restarts from zero: three samples are needed again.
    for (int i = 0; i < 2; i++)
      r.push_back(st(1'b1, 4'b0011, 4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b001, 3'b000, 1'b0));
    r.push_back(st(1'b1, 4'b0011, 4'h0, 4'h0, 3'b000, 4'h0, 3'b001, 3'b000, 3'b000, 1'b0));
    r.push_back(st(1'b1, 4'h0,    4'h0, 4'h0, 3'b001, 4'h0, 3'b000, 3'b000, 3'b001, 1'b0));
    r.push_back(st(1'b0, 4'h0,    4'h0, 4'h0, 3'b000, 4'h0, 3'b000, 3'b000, 3'b000, 1'b0));
    foreach (r[i]) begin
      apply(r[i]);
      obs = {votes, pending, clear_ack, degraded}; want = exp_q.pop_front();
      n_checks++;
      if (obs !== want) begin
        n_errors++;
        $display("FAIL async_reset_post step %0d: got %b want %b", i, obs, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_trip();
    test_single_div();
    test_restart();
    test_clear();
    test_bypass();
    test_async_reset();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
